// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioner: channel indices,
// repeat FSM states and a counter-width helper.
package btn_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_THROW = 2;
    localparam int N_BTN     = 3;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_REPEAT
    } rep_state_t;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pad inputs, the conditioner and the game core.
// The conditioner takes the master side; the consumer takes the slave side.
interface button_conditioner_if
    import btn_pkg::*;
#(
    parameter int N_BTN = btn_pkg::N_BTN
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

endinterface

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-flop synchronizer, debounce counter, accepted level and
// registered one-cycle press/release pulses.
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;

    assign s = sync[1];

    // NOTE: non-blocking assignments make every flop here sample pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync          <= '0;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[0], raw};
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level         <= s;
                cnt           <= '0;
                press_pulse   <= s;
                release_pulse <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel debounce cells plus an optional
// auto-repeat FSM per channel, built only when AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = btn_pkg::N_BTN,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_RATE     = 5000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b011
) (
    input logic                  CLK,
    input logic                  RST_N,
    button_conditioner_if.master bus
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        $bits(REPEAT_MASK) != N_BTN) begin : g_bad_params
        $error("button_conditioner: illegal parameter set");
    end

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] cell_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .CLK          (CLK),
            .RST_N        (RST_N),
            .raw          (bus.btn_raw[i]),
            .level        (level[i]),
            .press_pulse  (cell_press[i]),
            .release_pulse(bus.btn_release[i])
        );
    end

    assign bus.btn_level = level;

`ifdef AUTOREPEAT_EN
    localparam int RCW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

    logic [N_BTN-1:0] rep_fire;

    for (genvar i = 0; i < N_BTN; i++) begin : g_rep
        if (REPEAT_MASK[i]) begin : g_on
            rep_state_t     state, state_next;
            logic [RCW-1:0] cnt, cnt_next;
            logic           fire;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state <= REP_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_next;
                    cnt   <= cnt_next;
                end
            end

            // NOTE: defaults come first so no path through the case infers a latch.
            always_comb begin
                state_next = state;
                cnt_next   = cnt;
                fire       = 1'b0;
                case (state)
                    REP_IDLE: begin
                        if (cell_press[i]) begin
                            state_next = REP_DELAY;
                            cnt_next   = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (cnt == DELAY_LAST) begin
                            fire       = 1'b1;
                            cnt_next   = '0;
                            state_next = REP_REPEAT;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                    REP_REPEAT: begin
                        if (cnt == RATE_LAST) begin
                            fire     = 1'b1;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                    default: state_next = REP_IDLE;
                endcase
                // A released level aborts repeating and suppresses a coincident repeat.
                if (!level[i]) begin
                    state_next = REP_IDLE;
                    cnt_next   = '0;
                    fire       = 1'b0;
                end
            end

            assign rep_fire[i] = fire;
        end else begin : g_off
            assign rep_fire[i] = 1'b0;
        end
    end

    assign bus.btn_press = cell_press | rep_fire;
`else
    assign bus.btn_press = cell_press;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3; expectations follow AUTOREPEAT_EN when it is defined.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int NB = btn_pkg::N_BTN;
    localparam logic [NB-1:0] L    = NB'(1) << BTN_LEFT;
    localparam logic [NB-1:0] R    = NB'(1) << BTN_RIGHT;
    localparam logic [NB-1:0] T    = NB'(1) << BTN_THROW;
    localparam logic [NB-1:0] NONE = '0;
    localparam logic [NB-1:0] ALL  = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    button_conditioner_if #(.N_BTN(NB)) bus ();

    button_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .REPEAT_MASK    (3'b011)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs change here too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press expected at cycle k for a repeat-enabled channel first pressed at t0.
    function automatic logic hit(input int k, input int t0);
        logic r;
        r = (k == t0);
`ifdef AUTOREPEAT_EN
        if (k >= t0 + 10 && (k - t0 - 10) % 3 == 0) r = 1'b1;
`endif
        return r;
    endfunction

    task automatic check_all(input string tst, input int k, input logic [NB-1:0] el,
                             input logic [NB-1:0] ep, input logic [NB-1:0] er);
        check($sformatf("%s_level_k%0d", tst, k), bus.btn_level, el);
        check($sformatf("%s_press_k%0d", tst, k), bus.btn_press, ep);
        check($sformatf("%s_release_k%0d", tst, k), bus.btn_release, er);
    endtask

    initial begin
        logic [NB-1:0] ep;
        logic [NB-1:0] er;
        logic [NB-1:0] el;

        // 1: reset with all buttons held, then release reset.
        bus.btn_raw = ALL;
        rst_n = 1'b0;
        repeat (3) step();
        check_all("t1_rst", 0, NONE, NONE, NONE);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            el = (k >= 6 && k < 13) ? ALL : NONE;
            ep = (k == 6) ? ALL : NONE;
            er = (k == 13) ? ALL : NONE;
            check_all("t1", k, el, ep, er);
            if (k == 7) bus.btn_raw = NONE;
        end

        // 2: three-cycle glitch on left is rejected.
        bus.btn_raw = L;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_all("t2", k, NONE, NONE, NONE);
            if (k == 3) bus.btn_raw = NONE;
        end

        // 3: right bounces every 2 cycles, settles high at slot 12, drops at slot 18.
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) begin
                step();
                el = (k >= 18 && k < 24) ? R : NONE;
                ep = (k == 18) ? R : NONE;
                er = (k == 24) ? R : NONE;
                check_all("t3", k, el, ep, er);
            end
            if (k < 12)       bus.btn_raw = ((k / 2) % 2 == 0) ? R : NONE;
            else if (k < 18)  bus.btn_raw = R;
            else              bus.btn_raw = NONE;
        end

        // 4: hold left + throw; only left repeats.
        bus.btn_raw = L | T;
        for (int k = 1; k <= 40; k++) begin
            step();
            ep = NONE;
            ep[BTN_LEFT]  = hit(k, 6);
            ep[BTN_THROW] = (k == 6);
            el = (k >= 6) ? (L | T) : NONE;
            check_all("t4", k, el, ep, NONE);
        end

        // 5: asynchronous reset mid-repeat, then recover with buttons still held.
        rst_n = 1'b0;
        #1;
        check_all("t5_rst", 0, NONE, NONE, NONE);
        step();
        step();
        check_all("t5_rst", 1, NONE, NONE, NONE);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            ep = NONE;
            ep[BTN_LEFT]  = hit(k, 6) && (k < 37);
            ep[BTN_THROW] = (k == 6);
            er = (k == 37) ? (L | T) : NONE;
            el = (k >= 6 && k < 37) ? (L | T) : NONE;
            check_all("t5", k, el, ep, er);
            if (k == 31) bus.btn_raw = NONE;
        end

        // 6: left + right together; left released while right keeps repeating.
        bus.btn_raw = L | R;
        for (int k = 1; k <= 41; k++) begin
            step();
            ep = NONE;
            ep[BTN_LEFT]  = hit(k, 6) && (k < 23);
            ep[BTN_RIGHT] = hit(k, 6) && (k < 40);
            er = ((k == 23) ? L : NONE) | ((k == 40) ? R : NONE);
            el = ((k >= 6 && k < 23) ? L : NONE) | ((k >= 6 && k < 40) ? R : NONE);
            check_all("t6", k, el, ep, er);
            if (k == 17) bus.btn_raw = R;
            if (k == 34) bus.btn_raw = NONE;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
